detector_arbiter: RTL and testbench

DETECTOR_ARBITER -- requirements
Module: detector_arbiter

---
 rtl/detector_arbiter.sv | 174 +++++++++++++++++
 tb/tb_detector_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/detector_arbiter.sv
// detector_arbiter: round-robin grant of one serial "01" detector among N requesters.
// Latency: grant one edge after req seen in IDLE; z one edge after the detecting bit.
// Backpressure: granted requester owns the detector until last/abort (or burst limit
//    when built with DET_ARB_TIMEOUT_EN); others wait, with a FLUSH+IDLE gap between grants.
module detector_arbiter #(
   parameter int N         = 4,
   parameter int MAX_BURST = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N-1:0]           req,
   input  logic [N-1:0]           bit_in,
   input  logic [N-1:0]           last,
   output logic [N-1:0]           gnt,
   output logic                   z,
   output logic [$clog2(N)-1:0]   z_src,
   output logic                   busy,
   output logic                   timeout
);

   localparam int IW = $clog2(N);

   // Elaboration-time range guard on the configuration.
   if (N < 2 || N > 8 || MAX_BURST < 2 || MAX_BURST > 255) begin : g_bad_param
      $error("detector_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {IDLE, GRANT, FLUSH} arb_state_t;
   typedef enum logic [1:0] {DET_A, DET_B, DET_C} det_state_t;

   arb_state_t      state_q, state_d;
   det_state_t      det_q, det_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   g_q, g_d;
   logic [N-1:0]    gnt_d;
   logic            z_d;
   logic [IW-1:0]   z_src_d;
   logic            timeout_d;
   logic [IW-1:0]   sel;
   logic            found;
   logic            cur_bit;

`ifdef DET_ARB_TIMEOUT_EN
   localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
   logic [7:0]      cnt_q, cnt_d;
`endif

   // Round-robin pick: first requester at or after ptr, wrapping mod N.
   always_comb begin
      int j;
      logic [IW-1:0] idx;
      sel   = '0;
      found = 1'b0;
      j     = 0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         j = int'(ptr_q) + i;
         if (j >= N) j = j - N;
         idx = IW'(j);
         if (!found && req[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   // Next-state and next-output logic for arbiter, detector and burst counter.
   always_comb begin
      state_d   = state_q;
      det_d     = det_q;
      ptr_d     = ptr_q;
      g_d       = g_q;
      gnt_d     = gnt;
      z_d       = 1'b0;
      z_src_d   = z_src;
      timeout_d = 1'b0;
      cur_bit   = bit_in[g_q];
`ifdef DET_ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (found) begin
               state_d    = GRANT;
               g_d        = sel;
               gnt_d[sel] = 1'b1;
               det_d      = DET_A;
`ifdef DET_ARB_TIMEOUT_EN
               cnt_d      = '0;
`endif
            end
         end
         GRANT: begin
            if (req[g_q]) begin
               // Sample the granted requester's bit; only B->1 is a detect.
               det_d = cur_bit ? DET_C : DET_B;
               if (det_q == DET_B && cur_bit) begin
                  z_d     = 1'b1;
                  z_src_d = g_q;
               end
`ifdef DET_ARB_TIMEOUT_EN
               cnt_d = cnt_q + 8'd1;
               if (last[g_q]) begin
                  state_d = FLUSH;
                  gnt_d   = '0;
               end else if (cnt_q == BURST_LAST) begin
                  // Limit reached without last: revoke and flag it.
                  state_d   = FLUSH;
                  gnt_d     = '0;
                  timeout_d = 1'b1;
               end
`else
               if (last[g_q]) begin
                  state_d = FLUSH;
                  gnt_d   = '0;
               end
`endif
            end else begin
               // Requester aborted: nothing sampled this cycle.
               state_d = FLUSH;
               gnt_d   = '0;
            end
         end
         FLUSH: begin
            gnt_d   = '0;
            det_d   = DET_A;
            ptr_d   = (g_q == IW'(N - 1)) ? '0 : g_q + 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // State and output registers; synchronous reset overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         det_q   <= DET_A;
         ptr_q   <= '0;
         g_q     <= '0;
         gnt     <= '0;
         z       <= 1'b0;
         z_src   <= '0;
         timeout <= 1'b0;
`ifdef DET_ARB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         det_q   <= det_d;
         ptr_q   <= ptr_d;
         g_q     <= g_d;
         gnt     <= gnt_d;
         z       <= z_d;
         z_src   <= z_src_d;
         timeout <= timeout_d;
`ifdef DET_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

`ifndef DET_ARB_TIMEOUT_EN
   logic unused_timeout_d;
   assign unused_timeout_d = timeout_d;
`endif

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_detector_arbiter.sv
// Scoreboard bench for detector_arbiter: directed bursts with hand-computed z/timeout/grant events.
// Stimulus pushes expected events; a monitor on the falling edge pops and compares.
module tb_detector_arbiter;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req, bit_in, last, gnt;
   logic         z, busy, timeout;
   logic [1:0]   z_src;

   detector_arbiter #(.N(N), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .last(last),
      .gnt(gnt), .z(z), .z_src(z_src), .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int compared = 0;
   int mismatched = 0;

   typedef struct {int cyc; int src;} ev_t;
   ev_t          zq[$];
   int           tq[$];
   logic [N-1:0] gq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares DUT events against the expectation queues.
   initial begin
      ev_t ev;
      int tc;
      logic [N-1:0] gnt_prev;
      gnt_prev = '0;
      forever begin
         @(negedge clk);
         chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
         while (zq.size() > 0 && zq[0].cyc < cyc) begin
            ev = zq.pop_front();
            chk("z_missing", 0, 1);
         end
         if (z === 1'b1) begin
            if (zq.size() == 0) chk("z_unexpected", 1, 0);
            else begin
               ev = zq.pop_front();
               chk("z_cycle", cyc, ev.cyc);
               chk("z_src", 32'(z_src), ev.src);
            end
         end
         while (tq.size() > 0 && tq[0] < cyc) begin
            tc = tq.pop_front();
            chk("timeout_missing", 0, 1);
         end
         if (timeout === 1'b1) begin
            if (tq.size() == 0) chk("timeout_unexpected", 1, 0);
            else begin
               tc = tq.pop_front();
               chk("timeout_cycle", cyc, tc);
            end
         end
         if (gnt !== '0 && gnt_prev === '0) begin
            if (gq.size() == 0) chk("gnt_unexpected", 32'(gnt), 0);
            else chk("gnt_order", 32'(gnt), 32'(gq.pop_front()));
         end
         gnt_prev = gnt;
      end
   end

   // Serve one burst for requester idx. mode 0: last on final bit, 1: abort after bits,
   // 2: burst limit expected on final bit. Non-granted lanes get the opposite data.
   task automatic serve(input logic [1:0] idx, input logic [15:0] bits, input int n,
                        input logic [15:0] expz, input int mode);
      int w;
      logic [N-1:0] e;
      logic b;
      e = '0;
      e[idx] = 1'b1;
      w = 0;
      while (gnt[idx] !== 1'b1 && w < 40) begin
         @(negedge clk);
         w++;
      end
      if (gnt[idx] !== 1'b1) begin
         chk("gnt_wait", 32'(gnt), 32'(e));
         req[idx] = 1'b0;
         return;
      end
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge clk);
         b = bits[i[3:0]];
         bit_in = {N{~b}};
         bit_in[idx] = b;
         last = ~e;
         last[idx] = (mode == 0 && i == n - 1);
         if (expz[i[3:0]]) zq.push_back('{cyc + 1, int'(idx)});
         if (mode == 2 && i == n - 1) tq.push_back(cyc + 1);
      end
      @(negedge clk);
      if (mode == 1) begin
         req[idx] = 1'b0;
         bit_in = '1;
         last = '0;
         @(negedge clk);
      end
      chk("flush_gnt", 32'(gnt), 0);
      chk("flush_busy", 32'(busy), 1);
      req[idx] = 1'b0;
      bit_in = '1;
      last = '0;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_gnt"}, 32'(gnt), 0);
      chk({tag, "_z"}, 32'(z), 0);
      chk({tag, "_z_src"}, 32'(z_src), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_timeout"}, 32'(timeout), 0);
   endtask

   initial begin
      int w;
      rst = 1'b1;
      req = '0;
      bit_in = '0;
      last = '0;
      repeat (2) @(negedge clk);
      check_cleared("reset");
      rst = 1'b0;

      // Single requester, bits 1,0,1,0: one z after the 3rd bit.
      @(negedge clk);
      req = 4'b0001;
      gq.push_back(4'b0001);
      @(negedge clk);
      chk("t1_gnt_latency", 32'(gnt), 32'b0001);
      serve(2'd0, 16'b0101, 4, 16'b0100, 0);

      // Back to ptr=0, then two requesters: 0 first, then 3 with no carried pattern.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req = 4'b1001;
      gq.push_back(4'b0001);
      gq.push_back(4'b1000);
      serve(2'd0, 16'b010, 3, 16'b010, 0);
      serve(2'd3, 16'b01, 2, 16'b0, 0);
      // Pointer wrapped to 0: requester 0 beats 1.
      req = 4'b0011;
      gq.push_back(4'b0001);
      gq.push_back(4'b0010);
      serve(2'd0, 16'b1, 1, 16'b0, 0);
      serve(2'd1, 16'b0, 1, 16'b0, 0);

      // Abort after a 0, then a fresh grant starting from A.
      req = 4'b0010;
      gq.push_back(4'b0010);
      serve(2'd1, 16'b0, 1, 16'b0, 1);
      req = 4'b0010;
      gq.push_back(4'b0010);
      serve(2'd1, 16'b01, 2, 16'b0, 0);

      // Reset mid-burst while detector sits in B.
      req = 4'b0001;
      gq.push_back(4'b0001);
      w = 0;
      while (gnt[0] !== 1'b1 && w < 40) begin
         @(negedge clk);
         w++;
      end
      chk("t4_gnt", 32'(gnt), 32'b0001);
      bit_in = 4'b1110;
      @(negedge clk);
      rst = 1'b1;
      bit_in = '1;
      @(negedge clk);
      check_cleared("midburst_reset");
      rst = 1'b0;
      req = 4'b0110;
      gq.push_back(4'b0010);
      gq.push_back(4'b0100);
      serve(2'd1, 16'b1, 1, 16'b0, 0);
      serve(2'd2, 16'b10, 2, 16'b10, 0);

`ifdef DET_ARB_TIMEOUT_EN
      // Limit of 4: bits 0,1,0,0 then revoked with timeout.
      req = 4'b0001;
      gq.push_back(4'b0001);
      serve(2'd0, 16'b0010, 4, 16'b0010, 2);
      // last on the 4th bit is a normal end.
      req = 4'b0001;
      gq.push_back(4'b0001);
      serve(2'd0, 16'b1010, 4, 16'b1010, 0);
`else
      // Unbounded: all six bits 0,1,0,0,0,1 sampled, no timeout.
      req = 4'b0001;
      gq.push_back(4'b0001);
      serve(2'd0, 16'b100010, 6, 16'b100010, 1);
`endif

      repeat (3) @(negedge clk);
      chk("z_queue_drained", zq.size(), 0);
      chk("timeout_queue_drained", tq.size(), 0);
      chk("gnt_queue_drained", gq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

endmodule
